// File: rtl/axis_rob_pkg.sv
// Shared types and helpers for the tagged in-order reorder buffer.
//   rob_state_t : per-entry lifecycle state
//   rob_depth() : entry count derived from the log2 depth parameter
package axis_rob_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        ALLOC  = 2'd1,
        ISSUED = 2'd2,
        DONE   = 2'd3
    } rob_state_t;

    function automatic int unsigned rob_depth(input int unsigned ld);
        return 32'd1 << ld;
    endfunction

endpackage

// File: rtl/rob_dpram.sv
// Simple payload store: one synchronous write port, one asynchronous read port.
// Ports:
//   clk            write clock
//   we/waddr/wdata write port
//   raddr/rdata    combinational read port
// Contents are not reset; the owner tracks validity separately.
module rob_dpram
    import axis_rob_pkg::*;
#(
    parameter int unsigned W  = 12,
    parameter int unsigned AW = 5
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    localparam int unsigned DEPTH = rob_depth(AW);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axis_rob.sv
// In-order reorder buffer: allocate in order, issue in order with a
// {phase, index} tag, complete out of order by tag, retire in order.
// Ports:
//   clk, rst                          clock, async active-high reset
//   flush                             discard all outstanding entries
//   req_valid/req_data/req_ready      allocation channel
//   iss_valid/iss_data/iss_tag/iss_ready  issue channel
//   rsp_valid/rsp_tag/rsp_data/rsp_ready  completion channel (always ready)
//   out_valid/out_data/out_ready      retire channel
//   occupancy                         allocated-but-unretired count
//   err_stale                         pulse when a completion is dropped
module axis_rob
    import axis_rob_pkg::*;
#(
    parameter int unsigned REQ_W  = 12,
    parameter int unsigned RESP_W = 12,
    parameter int unsigned LD     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req_valid,
    input  logic [REQ_W-1:0]  req_data,
    output logic              req_ready,
    output logic              iss_valid,
    output logic [REQ_W-1:0]  iss_data,
    output logic [LD:0]       iss_tag,
    input  logic              iss_ready,
    input  logic              rsp_valid,
    input  logic [LD:0]       rsp_tag,
    input  logic [RESP_W-1:0] rsp_data,
    output logic              rsp_ready,
    output logic              out_valid,
    output logic [RESP_W-1:0] out_data,
    input  logic              out_ready,
    output logic [LD:0]       occupancy,
    output logic              err_stale
);

    localparam int unsigned DEPTH = rob_depth(LD);
    localparam int unsigned PW    = LD + 1;

    logic [LD:0]       alloc_ptr, issue_ptr, retire_ptr;
    rob_state_t        state [DEPTH];
    logic [DEPTH-1:0]  phase;

    logic [LD-1:0] alloc_idx, issue_idx, retire_idx, rsp_idx;
    logic          alloc_fire, issue_fire, retire_fire, rsp_hit;

    assign alloc_idx  = alloc_ptr[LD-1:0];
    assign issue_idx  = issue_ptr[LD-1:0];
    assign retire_idx = retire_ptr[LD-1:0];
    assign rsp_idx    = rsp_tag[LD-1:0];

    // Handshake status is derived from registered pointers/state only.
    assign occupancy = alloc_ptr - retire_ptr;
    assign req_ready = (occupancy != PW'(DEPTH));
    assign iss_valid = (issue_ptr != alloc_ptr);
    assign iss_tag   = issue_ptr;
    assign out_valid = (state[retire_idx] == DONE);
    assign rsp_ready = 1'b1;

    assign alloc_fire  = req_valid && req_ready && !flush;
    assign issue_fire  = iss_valid && iss_ready && !flush;
    assign retire_fire = out_valid && out_ready && !flush;

    // A completion is genuine only for an issued entry of the same phase.
    assign rsp_hit = rsp_valid && (state[rsp_idx] == ISSUED)
                     && (phase[rsp_idx] == rsp_tag[LD]);

    rob_dpram #(.W(REQ_W), .AW(LD)) u_req_ram (
        .clk   (clk),
        .we    (alloc_fire),
        .waddr (alloc_idx),
        .wdata (req_data),
        .raddr (issue_idx),
        .rdata (iss_data)
    );

    rob_dpram #(.W(RESP_W), .AW(LD)) u_rsp_ram (
        .clk   (clk),
        .we    (rsp_hit && !flush),
        .waddr (rsp_idx),
        .wdata (rsp_data),
        .raddr (retire_idx),
        .rdata (out_data)
    );

    // Pointer and per-entry state update; the four events touch distinct entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alloc_ptr  <= '0;
            issue_ptr  <= '0;
            retire_ptr <= '0;
            phase      <= '0;
            err_stale  <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                state[i] <= FREE;
            end
        end else begin
            err_stale <= rsp_valid && !rsp_hit;
            if (flush) begin
                // Pointers keep advancing so later tags differ from flushed ones.
                issue_ptr  <= alloc_ptr;
                retire_ptr <= alloc_ptr;
                for (int i = 0; i < int'(DEPTH); i++) begin
                    state[i] <= FREE;
                end
            end else begin
                if (alloc_fire) begin
                    state[alloc_idx] <= ALLOC;
                    phase[alloc_idx] <= alloc_ptr[LD];
                    alloc_ptr        <= alloc_ptr + PW'(1);
                end
                if (issue_fire) begin
                    state[issue_idx] <= ISSUED;
                    issue_ptr        <= issue_ptr + PW'(1);
                end
                if (rsp_hit) begin
                    state[rsp_idx] <= DONE;
                end
                if (retire_fire) begin
                    state[retire_idx] <= FREE;
                    retire_ptr        <= retire_ptr + PW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_rob.sv
// Self-checking bench for axis_rob at LD=2 (4 entries, 3-bit tags).
// Directed table, hand-written corner sequences, then randomized traffic
// checked against a queue-based model of outstanding transactions.
module tb_axis_rob;

    localparam int unsigned LD = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        req_valid;
    logic [11:0] req_data;
    logic        req_ready;
    logic        iss_valid;
    logic [11:0] iss_data;
    logic [2:0]  iss_tag;
    logic        iss_ready;
    logic        rsp_valid;
    logic [2:0]  rsp_tag;
    logic [11:0] rsp_data;
    logic        rsp_ready;
    logic        out_valid;
    logic [11:0] out_data;
    logic        out_ready;
    logic [2:0]  occupancy;
    logic        err_stale;

    int checks   = 0;
    int failures = 0;

    axis_rob #(.REQ_W(12), .RESP_W(12), .LD(LD)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .iss_valid (iss_valid),
        .iss_data  (iss_data),
        .iss_tag   (iss_tag),
        .iss_ready (iss_ready),
        .rsp_valid (rsp_valid),
        .rsp_tag   (rsp_tag),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .occupancy (occupancy),
        .err_stale (err_stale)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled there too.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        flush = 1'b0; req_valid = 1'b0; req_data = '0; iss_ready = 1'b0;
        rsp_valid = 1'b0; rsp_tag = '0; rsp_data = '0; out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic do_alloc(input logic [11:0] d);
        req_valid = 1'b1; req_data = d; cycle(); req_valid = 1'b0;
    endtask

    task automatic do_issue();
        iss_ready = 1'b1; cycle(); iss_ready = 1'b0;
    endtask

    task automatic do_rsp(input logic [2:0] t, input logic [11:0] d);
        rsp_valid = 1'b1; rsp_tag = t; rsp_data = d; cycle(); rsp_valid = 1'b0;
    endtask

    task automatic do_retire();
        out_ready = 1'b1; cycle(); out_ready = 1'b0;
    endtask

    // Directed table: expected outputs observed now, then inputs applied at the next edge.
    typedef struct packed {
        logic        rv;
        logic [11:0] rd;
        logic        ir;
        logic        sv;
        logic [2:0]  st;
        logic [11:0] sd;
        logic        orr;
        logic [2:0]  e_occ;
        logic        e_rr;
        logic        e_iv;
        logic [2:0]  e_tag;
        logic        e_ov;
        logic [11:0] e_od;
        logic        e_err;
    } vec_t;

    vec_t tbl [14];

    task automatic run_table();
        tbl[0]  = '{1'b1, 12'h001, 1'b0, 1'b0, 3'd0, 12'h000, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 12'h000, 1'b0};
        tbl[1]  = '{1'b1, 12'h002, 1'b0, 1'b0, 3'd0, 12'h000, 1'b0, 3'd1, 1'b1, 1'b1, 3'd0, 1'b0, 12'h000, 1'b0};
        tbl[2]  = '{1'b1, 12'h003, 1'b0, 1'b0, 3'd0, 12'h000, 1'b0, 3'd2, 1'b1, 1'b1, 3'd0, 1'b0, 12'h000, 1'b0};
        tbl[3]  = '{1'b1, 12'h004, 1'b0, 1'b0, 3'd0, 12'h000, 1'b0, 3'd3, 1'b1, 1'b1, 3'd0, 1'b0, 12'h000, 1'b0};
        tbl[4]  = '{1'b0, 12'h000, 1'b1, 1'b0, 3'd0, 12'h000, 1'b0, 3'd4, 1'b0, 1'b1, 3'd0, 1'b0, 12'h000, 1'b0};
        tbl[5]  = '{1'b0, 12'h000, 1'b1, 1'b0, 3'd0, 12'h000, 1'b0, 3'd4, 1'b0, 1'b1, 3'd1, 1'b0, 12'h000, 1'b0};
        tbl[6]  = '{1'b0, 12'h000, 1'b1, 1'b0, 3'd0, 12'h000, 1'b0, 3'd4, 1'b0, 1'b1, 3'd2, 1'b0, 12'h000, 1'b0};
        tbl[7]  = '{1'b0, 12'h000, 1'b1, 1'b0, 3'd0, 12'h000, 1'b0, 3'd4, 1'b0, 1'b1, 3'd3, 1'b0, 12'h000, 1'b0};
        tbl[8]  = '{1'b0, 12'h000, 1'b0, 1'b1, 3'd0, 12'h001, 1'b0, 3'd4, 1'b0, 1'b0, 3'd0, 1'b0, 12'h000, 1'b0};
        tbl[9]  = '{1'b0, 12'h000, 1'b0, 1'b1, 3'd1, 12'h002, 1'b1, 3'd4, 1'b0, 1'b0, 3'd0, 1'b1, 12'h001, 1'b0};
        tbl[10] = '{1'b0, 12'h000, 1'b0, 1'b1, 3'd2, 12'h003, 1'b1, 3'd3, 1'b1, 1'b0, 3'd0, 1'b1, 12'h002, 1'b0};
        tbl[11] = '{1'b0, 12'h000, 1'b0, 1'b1, 3'd3, 12'h004, 1'b1, 3'd2, 1'b1, 1'b0, 3'd0, 1'b1, 12'h003, 1'b0};
        tbl[12] = '{1'b0, 12'h000, 1'b0, 1'b0, 3'd0, 12'h000, 1'b1, 3'd1, 1'b1, 1'b0, 3'd0, 1'b1, 12'h004, 1'b0};
        tbl[13] = '{1'b0, 12'h000, 1'b0, 1'b0, 3'd0, 12'h000, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 12'h000, 1'b0};
        for (int i = 0; i < 14; i++) begin
            chk($sformatf("tbl%0d_occ", i), 32'(occupancy), 32'(tbl[i].e_occ));
            chk($sformatf("tbl%0d_req_ready", i), 32'(req_ready), 32'(tbl[i].e_rr));
            chk($sformatf("tbl%0d_iss_valid", i), 32'(iss_valid), 32'(tbl[i].e_iv));
            if (tbl[i].e_iv) chk($sformatf("tbl%0d_iss_tag", i), 32'(iss_tag), 32'(tbl[i].e_tag));
            chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            if (tbl[i].e_ov) chk($sformatf("tbl%0d_out_data", i), 32'(out_data), 32'(tbl[i].e_od));
            chk($sformatf("tbl%0d_err", i), 32'(err_stale), 32'(tbl[i].e_err));
            req_valid = tbl[i].rv;  req_data = tbl[i].rd;  iss_ready = tbl[i].ir;
            rsp_valid = tbl[i].sv;  rsp_tag  = tbl[i].st;  rsp_data  = tbl[i].sd;
            out_ready = tbl[i].orr;
            cycle();
        end
        clear_inputs();
    endtask

    // Reference model: outstanding transactions in allocation order.
    typedef struct {
        logic [11:0] req;
        logic [2:0]  tag;
        bit          issued;
        bit          done;
        logic [11:0] resp;
    } ent_t;

    ent_t        mq[$];
    int unsigned m_alloc;
    bit          m_err;

    task automatic run_random(input int n);
        for (int c = 0; c < n; c++) begin
            int   first_un;
            int   acc;
            int   cand[$];
            bit   e_ov, e_rr, f, rv, ir, sv, orr, n_err;
            logic [2:0]  st;
            logic [11:0] rd, sd;
            ent_t e;

            first_un = -1;
            for (int k = 0; k < mq.size(); k++)
                if (!mq[k].issued && first_un < 0) first_un = k;
            e_rr = (mq.size() < 4);
            e_ov = (mq.size() > 0) && mq[0].done;
            chk("rnd_occ", 32'(occupancy), 32'(mq.size()));
            chk("rnd_req_ready", 32'(req_ready), 32'(e_rr));
            chk("rnd_iss_valid", 32'(iss_valid), 32'(first_un >= 0));
            if (first_un >= 0) begin
                chk("rnd_iss_tag", 32'(iss_tag), 32'(mq[first_un].tag));
                chk("rnd_iss_data", 32'(iss_data), 32'(mq[first_un].req));
            end
            chk("rnd_out_valid", 32'(out_valid), 32'(e_ov));
            if (e_ov) chk("rnd_out_data", 32'(out_data), 32'(mq[0].resp));
            chk("rnd_err_stale", 32'(err_stale), 32'(m_err));

            f   = ($urandom_range(0, 49) == 0);
            rv  = ($urandom_range(0, 9) < 6);
            ir  = ($urandom_range(0, 9) < 6);
            orr = ($urandom_range(0, 9) < 6);
            rd  = 12'($urandom);
            sd  = 12'($urandom);
            sv  = 1'b0;
            st  = 3'($urandom);
            if (!f) begin
                int r;
                r = int'($urandom_range(0, 9));
                for (int k = 0; k < mq.size(); k++)
                    if (mq[k].issued && !mq[k].done) cand.push_back(k);
                if (r < 5 && cand.size() > 0) begin
                    sv = 1'b1;
                    st = mq[cand[$urandom_range(0, cand.size() - 1)]].tag;
                end else if (r < 6) begin
                    sv = 1'b1;
                end
            end

            flush = f; req_valid = rv; req_data = rd; iss_ready = ir;
            rsp_valid = sv; rsp_tag = st; rsp_data = sd; out_ready = orr;

            n_err = 1'b0;
            if (f) begin
                mq.delete();
            end else begin
                acc = -1;
                if (sv)
                    for (int k = 0; k < mq.size(); k++)
                        if (mq[k].tag == st && mq[k].issued && !mq[k].done) acc = k;
                n_err = sv && (acc < 0);
                if (acc >= 0) begin
                    mq[acc].done = 1'b1;
                    mq[acc].resp = sd;
                end
                if (ir && first_un >= 0) mq[first_un].issued = 1'b1;
                if (e_ov && orr) void'(mq.pop_front());
                if (rv && e_rr) begin
                    e.req = rd; e.tag = 3'(m_alloc); e.issued = 1'b0; e.done = 1'b0; e.resp = '0;
                    mq.push_back(e);
                    m_alloc++;
                end
            end
            m_err = n_err;
            cycle();
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_iss_valid", 32'(iss_valid), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_occupancy", 32'(occupancy), 32'd0);
        chk("reset_err_stale", 32'(err_stale), 32'd0);
        chk("reset_rsp_ready", 32'(rsp_ready), 32'd1);
        rst = 1'b0;

        // Fill / drain
        run_table();

        // Reorder: completions 3,1,0,2 retire as A,B,C,D
        do_reset();
        do_alloc(12'h0F1); do_alloc(12'h0F2); do_alloc(12'h0F3); do_alloc(12'h0F4);
        for (int i = 0; i < 4; i++) begin
            chk("reorder_iss_tag", 32'(iss_tag), 32'(i));
            do_issue();
        end
        do_rsp(3'd3, 12'h00D);
        chk("reorder_err_t3", 32'(err_stale), 32'd0);
        chk("reorder_ov_t3", 32'(out_valid), 32'd0);
        do_rsp(3'd1, 12'h00B);
        chk("reorder_ov_t1", 32'(out_valid), 32'd0);
        do_rsp(3'd0, 12'h00A);
        chk("reorder_ov_t0", 32'(out_valid), 32'd1);
        chk("reorder_out_A", 32'(out_data), 32'h00A);
        rsp_valid = 1'b1; rsp_tag = 3'd2; rsp_data = 12'h00C; out_ready = 1'b1;
        cycle();
        clear_inputs();
        chk("reorder_out_B", 32'(out_data), 32'h00B);
        do_retire();
        chk("reorder_out_C", 32'(out_data), 32'h00C);
        do_retire();
        chk("reorder_out_D", 32'(out_data), 32'h00D);
        do_retire();
        chk("reorder_drained_ov", 32'(out_valid), 32'd0);
        chk("reorder_drained_occ", 32'(occupancy), 32'd0);

        // Wrap / phase, with a stale same-index response on round 5
        do_reset();
        for (int i = 0; i < 10; i++) begin
            do_alloc(12'(32'h010 + i));
            chk("wrap_iss_valid", 32'(iss_valid), 32'd1);
            chk("wrap_iss_tag", 32'(iss_tag), 32'(i % 8));
            chk("wrap_iss_data", 32'(iss_data), 32'h010 + 32'(i));
            do_issue();
            if (i == 5) begin
                do_rsp(3'd1, 12'hEEE);
                chk("stale_err_pulse", 32'(err_stale), 32'd1);
                chk("stale_no_done", 32'(out_valid), 32'd0);
                cycle();
                chk("stale_err_clear", 32'(err_stale), 32'd0);
            end
            do_rsp(3'(i % 8), 12'(32'h200 + i));
            chk("wrap_rsp_err", 32'(err_stale), 32'd0);
            chk("wrap_out_valid", 32'(out_valid), 32'd1);
            chk("wrap_out_data", 32'(out_data), 32'h200 + 32'(i));
            do_retire();
            chk("wrap_occ", 32'(occupancy), 32'd0);
        end

        // Duplicate completion of tag 2
        do_alloc(12'h333);
        chk("dup_iss_tag", 32'(iss_tag), 32'd2);
        do_issue();
        do_rsp(3'd2, 12'h5A5);
        chk("dup_first_err", 32'(err_stale), 32'd0);
        chk("dup_first_ov", 32'(out_valid), 32'd1);
        do_rsp(3'd2, 12'h777);
        chk("dup_second_err", 32'(err_stale), 32'd1);
        chk("dup_out_data", 32'(out_data), 32'h5A5);
        do_retire();
        chk("dup_retired", 32'(out_valid), 32'd0);

        // Flush with 3 allocated, 2 issued (tags 3,4 issued, 5 pending)
        do_alloc(12'h101); do_alloc(12'h102); do_alloc(12'h103);
        do_issue(); do_issue();
        chk("flush_pre_occ", 32'(occupancy), 32'd3);
        flush = 1'b1; cycle(); flush = 1'b0;
        chk("flush_occ", 32'(occupancy), 32'd0);
        chk("flush_iss_valid", 32'(iss_valid), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_req_ready", 32'(req_ready), 32'd1);
        do_rsp(3'd3, 12'h0AB);
        chk("flush_late_err", 32'(err_stale), 32'd1);
        do_alloc(12'h009);
        chk("flush_new_tag", 32'(iss_tag), 32'd6);
        chk("flush_new_data", 32'(iss_data), 32'h009);

        // Asynchronous reset between clock edges with three outstanding
        do_reset();
        do_alloc(12'h021); do_alloc(12'h022); do_alloc(12'h023);
        do_issue();
        chk("areset_pre_occ", 32'(occupancy), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("areset_occ", 32'(occupancy), 32'd0);
        chk("areset_req_ready", 32'(req_ready), 32'd1);
        chk("areset_iss_valid", 32'(iss_valid), 32'd0);
        chk("areset_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_rsp(3'd0, 12'h055);
        chk("areset_stale_err", 32'(err_stale), 32'd1);

        // Randomized traffic against the model
        do_reset();
        mq.delete();
        m_alloc = 0;
        m_err   = 1'b0;
        run_random(1500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
